// File: rtl/a2d_intf.sv
// ---------------------------------------------------------------------------
// a2d_intf
//   Periodic SPI master for an external A2D converter. Each conversion round
//   sends a channel command in one 16-bit transaction. After a 2-clk
//   deselect gap, a second 16-bit transaction reads back the result. The
//   low 12 bits are stored in the result register for that channel.
//   Channels are visited round-robin: 0 (batt) -> 1 (curr) -> 4 (torque).
//
// Parameters
//   PERIOD_W   : width of the free-running timer; a round starts every
//                2^PERIOD_W clk (when the FSM is idle).
//   SCLK_DIV_W : width of the SCLK divider; SCLK period = 2^SCLK_DIV_W clk.
//
// Ports
//   clk        : system clock, all logic on posedge
//   rst_n      : asynchronous active-low reset
//   SS_n       : SPI slave select, active-low
//   SCLK       : SPI clock, idles high
//   MOSI       : serial command, MSB first
//   MISO       : serial data from the A2D, MSB first
//   batt       : last channel-0 result
//   curr       : last channel-1 result
//   torque     : last channel-4 result
//   cnv_cmplt  : one-clk pulse coincident with a result register update
// ---------------------------------------------------------------------------
module a2d_intf #(
  parameter int PERIOD_W   = 14,
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        cnv_cmplt
);

  // Divider landmarks. The load value keeps SCLK high and places the first
  // falling edge a few clocks after SS_n drops. This gives the slave setup time.
  localparam logic [SCLK_DIV_W-1:0] DIV_LOAD   = {2'b10, {(SCLK_DIV_W-2){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_SAMPLE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_FALL   = {SCLK_DIV_W{1'b1}};

  typedef enum logic [2:0] {IDLE, CMD, GAP, READ, STORE} state_t;
  typedef enum logic [2:0] {CH_BATT = 3'd0, CH_CURR = 3'd1, CH_TORQ = 3'd4} ch_t;

  state_t                state, next_state;
  ch_t                   ch;
  logic [PERIOD_W-1:0]   timer;
  logic [SCLK_DIV_W-1:0] div;
  logic [4:0]            smpl_cnt;
  logic                  gap_cnt;
  logic [15:0]           tx;
  // Only the last 12 bits shifted in are ever stored, so older bits fall off.
  logic [11:0]           rx;

  logic        start_req;
  logic        xfer_active;
  logic        div_rise;
  logic        div_fall;
  logic        xfer_done;
  logic [15:0] cmd_word;

  function automatic ch_t next_ch(input ch_t c);
    case (c)
      CH_BATT: return CH_CURR;
      CH_CURR: return CH_TORQ;
      default: return CH_BATT;
    endcase
  endfunction

  assign start_req   = &timer;  // timer about to roll over to 0
  assign xfer_active = (state == CMD) || (state == READ);
  assign div_rise    = (div == DIV_SAMPLE);
  assign div_fall    = (div == DIV_FALL);
  assign xfer_done   = xfer_active && div_fall && (smpl_cnt == 5'd16);
  assign cmd_word    = {2'b00, ch, 11'h000};

  // SS_n and the divider MSB are both registers. At every SS_n edge the divider
  // MSB is 1 (load value or stopped at all-ones), so SCLK stays high throughout.
  assign SCLK = SS_n | div[SCLK_DIV_W-1];
  assign MOSI = tx[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: next_state gets a default before the case. Every path then
    // assigns it, and no latch is inferred.
    next_state = state;
    case (state)
      IDLE:    if (start_req) next_state = CMD;
      CMD:     if (xfer_done) next_state = GAP;
      GAP:     if (gap_cnt)   next_state = READ;
      READ:    if (xfer_done) next_state = STORE;
      STORE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      div       <= DIV_LOAD;
      smpl_cnt  <= '0;
      gap_cnt   <= 1'b0;
      tx        <= '0;
      rx        <= '0;
      SS_n      <= 1'b1;
      batt      <= '0;
      curr      <= '0;
      torque    <= '0;
      cnv_cmplt <= 1'b0;
      ch        <= CH_BATT;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      timer     <= timer + 1'b1;
      cnv_cmplt <= 1'b0;
      case (state)
        IDLE: begin
          if (start_req) begin
            SS_n     <= 1'b0;
            div      <= DIV_LOAD;
            smpl_cnt <= '0;
            tx       <= cmd_word;
          end
        end
        CMD, READ: begin
          if (xfer_done) begin
            // Divider is left at all-ones, so SCLK stays high while deselected.
            SS_n    <= 1'b1;
            gap_cnt <= 1'b0;
          end else begin
            div <= div + 1'b1;
            if (div_rise) begin
              rx       <= {rx[10:0], MISO};
              smpl_cnt <= smpl_cnt + 5'd1;
            end
            // The first falling edge precedes any sample. MSB stays on MOSI.
            if (div_fall && (smpl_cnt != 5'd0)) tx <= {tx[14:0], 1'b0};
          end
        end
        GAP: begin
          gap_cnt <= 1'b1;
          if (gap_cnt) begin
            SS_n     <= 1'b0;
            div      <= DIV_LOAD;
            smpl_cnt <= '0;
            tx       <= cmd_word;
          end
        end
        STORE: begin
          case (ch)
            CH_BATT: batt   <= rx;
            CH_CURR: curr   <= rx;
            default: torque <= rx;
          endcase
          cnv_cmplt <= 1'b1;
          ch        <= next_ch(ch);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_intf.sv
// ---------------------------------------------------------------------------
// tb_a2d_intf
//   Self-checking bench for a2d_intf (PERIOD_W = 6, so the timer rolls over
//   many times inside each transaction). A cycle-sampled A2D slave answers
//   every round. It captures the command on SCLK rises and drives garbage
//   during the command window. It drives the response during the read window.
//   Expected result registers come from the round-robin channel order and the
//   responses the bench sent.
// ---------------------------------------------------------------------------
module tb_a2d_intf;

  localparam int PW  = 6;
  localparam int TMO = 4 * (1 << PW);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ss_n, sclk, mosi, miso;
  logic [11:0] batt, curr, torque;
  logic        cnv_cmplt;

  int n_checks = 0;
  int n_fails  = 0;

  logic [11:0] exp_batt, exp_curr, exp_torque;
  logic [2:0]  ch_seq [3] = '{3'd0, 3'd1, 3'd4};
  logic [11:0] fixed_resp [4] = '{12'hC00, 12'hBF1, 12'hBE4, 12'hBD0};

  a2d_intf #(.PERIOD_W(PW), .SCLK_DIV_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (ss_n),
    .SCLK      (sclk),
    .MOSI      (mosi),
    .MISO      (miso),
    .batt      (batt),
    .curr      (curr),
    .torque    (torque),
    .cnv_cmplt (cnv_cmplt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
    end
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_ss_n"},   ss_n,      1);
    check({tag, "_sclk"},   sclk,      1);
    check({tag, "_mosi"},   mosi,      0);
    check({tag, "_regs"},   {batt, curr, torque}, 36'h0);
    check({tag, "_cnv"},    cnv_cmplt, 0);
  endtask

  // One full round: wait for SS_n to drop, then play the A2D slave until
  // cnv_cmplt. With abort_fall > 0, reset is asserted mid-READ after that
  // many read-window SCLK falls, and the task returns.
  task automatic run_round(input logic [2:0] ch, input logic [15:0] resp,
                           input int abort_fall, output int wait_cyc);
    int          falls [2];
    int          win, gap, cyc, sclk_bad;
    bit          done;
    logic [15:0] cmd_cap, sh;
    logic        prev_sclk, prev_ss;
    falls = '{0, 0};
    win = 0; gap = 0; cyc = 0; sclk_bad = 0; done = 0;
    cmd_cap = '0;
    wait_cyc = 0;
    while (ss_n !== 1'b0 && wait_cyc < TMO) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("round_start", wait_cyc < TMO, 1);
    if (wait_cyc >= TMO) return;
    sh = ~resp;  // command-window data the DUT must discard
    prev_sclk = 1'b1;
    prev_ss   = 1'b0;
    while (!done && cyc < 4096) begin
      if (ss_n == 1'b0) begin
        if (prev_ss && win < 1) begin
          win++;
          sh = resp;
        end
        if (prev_sclk && !sclk) begin
          falls[win]++;
          miso = sh[15];
          sh   = sh << 1;
          if (abort_fall > 0 && win == 1 && falls[1] == abort_fall) begin
            #3 rst_n = 1'b0;
            #1 check_all_reset("abort");
            return;
          end
        end
        if (!prev_sclk && sclk && win == 0) cmd_cap = {cmd_cap[14:0], mosi};
      end else begin
        if (sclk !== 1'b1) sclk_bad++;
        if (win == 0) gap++;
      end
      if (cnv_cmplt) begin
        case (ch)
          3'd0:    exp_batt   = resp[11:0];
          3'd1:    exp_curr   = resp[11:0];
          default: exp_torque = resp[11:0];
        endcase
        check("store_after_read", {win[3:0], 27'd0, ss_n}, {4'd1, 27'd0, 1'b1});
        check("batt",   batt,   exp_batt);
        check("curr",   curr,   exp_curr);
        check("torque", torque, exp_torque);
        done = 1;
      end
      prev_sclk = sclk;
      prev_ss   = ss_n;
      @(negedge clk);
      cyc++;
    end
    check("round_done",     done,      1);
    check("cnv_pulse_1clk", cnv_cmplt, 0);
    check("cmd_falls",      falls[0],  16);
    check("read_falls",     falls[1],  16);
    check("gap_clks",       gap,       2);
    check("cmd_word",       cmd_cap,   {2'b00, ch, 11'h000});
    check("sclk_idle_high", sclk_bad,  0);
  endtask

  initial begin
    int w;
    int rnd;
    logic [15:0] resp;
    rst_n = 1'b0;
    miso  = 1'b0;
    exp_batt = '0; exp_curr = '0; exp_torque = '0;
    repeat (3) @(negedge clk);
    check_all_reset("reset");

    @(negedge clk);
    rst_n = 1'b1;
    rnd = 0;
    // Fixed-response rounds (ch0, ch1, ch4, wrap to ch0), then random ones.
    for (int i = 0; i < 6; i++) begin
      resp = $urandom;
      if (i < 4) resp[11:0] = fixed_resp[i];
      run_round(ch_seq[rnd % 3], resp, 0, w);
      if (i == 0) check("first_round_delay", w, 1 << PW);
      rnd++;
    end
    check("batt_final",   batt,   exp_batt);

    // Reset in the middle of a READ transaction.
    run_round(ch_seq[rnd % 3], 16'($urandom), 7, w);
    exp_batt = '0; exp_curr = '0; exp_torque = '0;
    repeat (3) @(negedge clk);
    check_all_reset("in_reset");
    rst_n = 1'b1;
    rnd = 0;
    for (int i = 0; i < 3; i++) begin
      run_round(ch_seq[rnd % 3], 16'($urandom), 0, w);
      if (i == 0) check("post_reset_delay", w, 1 << PW);
      rnd++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/a2d_intf.md
A2D_INTF -- requirements
Module: a2d_intf

Interface
REQ-001 SHALL provide parameter PERIOD_W, default 14: width of the free-running conversion timer, so a round starts every 2^PERIOD_W clk.
REQ-002 SHALL provide parameter SCLK_DIV_W, default 5: width of the SCLK divider, so SCLK period = 2^SCLK_DIV_W clk.
REQ-003 SHALL have port clk, input, 1: system clock; all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port SS_n, output, 1: SPI slave select to A2D, active-low.
REQ-006 SHALL have port SCLK, output, 1: SPI serial clock, idles high.
REQ-007 SHALL have port MOSI, output, 1: serial command to A2D, MSB first.
REQ-008 SHALL have port MISO, input, 1: serial data from A2D, MSB first.
REQ-009 SHALL have port batt, output, 12: last channel-0 result.
REQ-010 SHALL have port curr, output, 12: last channel-1 result.
REQ-011 SHALL have port torque, output, 12: last channel-4 result.
REQ-012 SHALL have port cnv_cmplt, output, 1: one-clk pulse when a result register updates.

Function
REQ-013 SHALL run a PERIOD_W-bit free-running timer; rollover to 0 raises a start request, ignored unless the FSM is IDLE.
REQ-014 SHALL sequence channels round-robin 0 -> 1 -> 4 -> 0; the pointer advances only on a completed round.
REQ-015 SHALL form each command word as {2'b00, ch[2:0], 11'h000}.
REQ-016 SHALL implement FSM states IDLE, CMD, GAP, READ, STORE.
REQ-017 IDLE: on start request, drop SS_n, load the divider with 5'b10111, go to CMD.
REQ-018 CMD: run one 16-bit transaction carrying the command word; at its end go to GAP.
REQ-019 GAP: hold SS_n high for exactly 2 clk, then drop SS_n, reload the divider, go to READ.
REQ-020 READ: run one 16-bit transaction with MOSI data don't-care (shift the same command); at its end go to STORE.
REQ-021 STORE: write rx[11:0] to the register for the current channel, pulse cnv_cmplt for 1 clk, advance the pointer, go to IDLE.
REQ-022 SHALL drive SCLK = divider MSB while SS_n is low, and 1 otherwise.
REQ-023 SHALL sample MISO into the rx shifter on the clk where the divider = 5'b01111 (SCLK rising).
REQ-024 SHALL shift the tx shifter (MOSI = tx[15]) on the clk where the divider = 5'b11111 (SCLK falling), except the first falling edge after SS_n drops.
REQ-025 SHALL end a transaction after the 16th sample, when the divider next reaches 5'b11111: SS_n rises, SCLK is high, and the divider stops.
REQ-026 SHALL discard the first-transaction rx data.
REQ-027 SHALL NOT change a result register outside STORE; the other two registers hold.
REQ-028 SHALL keep SCLK high with no glitch across SS_n edges.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force: FSM = IDLE, timer = 0, divider = 5'b10111, SS_n = 1, SCLK = 1, MOSI = 0, batt/curr/torque = 12'h000, cnv_cmplt = 0, pointer = ch0.
REQ-030 SHALL, on reset asserted mid-transaction, abort it immediately; the first round after release starts at ch0 after a full timer period.

Verification
REQ-031 SHALL cover: reset release, then a full period with the A2D model -> exactly 32 SCLK falls across two SS_n low windows separated by 2 clk SS_n high; batt = 12'hC00; cnv_cmplt pulses once.
REQ-032 SHALL cover: the second round -> curr = 12'hBF1; batt still 12'hC00.
REQ-033 SHALL cover: the third round -> torque = 12'hBE4; the fourth round -> batt = 12'hBD0 (wrap to ch0).
REQ-034 SHALL cover: MOSI checked on every SCLK rise during CMD -> bits equal {2'b00, ch, 11'h000}, MSB first, for ch = 0, 1, 4.
REQ-035 SHALL cover: rst_n pulsed low mid-READ -> SS_n = 1 and SCLK = 1 in the same cycle; all outputs 0; the next round targets ch0.
REQ-036 SHALL cover: PERIOD_W = 6 so timer rollovers occur during a transaction -> the extra start requests are ignored and there is no truncated transaction.
